// File: rtl/dmem_arbiter_if.sv
// Requester and DataMemory bus bundle for dmem_arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface dmem_arbiter_if;
    logic        Req0;
    logic        Wr0;
    logic [31:0] Addr0;
    logic [31:0] WData0;
    logic        Gnt0;
    logic        Done0;
    logic        Req1;
    logic        Wr1;
    logic [31:0] Addr1;
    logic [31:0] WData1;
    logic        Gnt1;
    logic        Done1;
    logic [31:0] RData;
    logic        Err;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [31:0] MemReadData;

    modport slave (
        input  Req0, Wr0, Addr0, WData0,
        input  Req1, Wr1, Addr1, WData1,
        input  MemReadData,
        output Gnt0, Done0, Gnt1, Done1,
        output RData, Err,
        output MemAddress, MemWriteData,
        output MemoryRead, MemoryWrite
    );

    modport master (
        output Req0, Wr0, Addr0, WData0,
        output Req1, Wr1, Addr1, WData1,
        output MemReadData,
        input  Gnt0, Done0, Gnt1, Done1,
        input  RData, Err,
        input  MemAddress, MemWriteData,
        input  MemoryRead, MemoryWrite
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the 64-word DataMemory.
// Ports: Clock, Reset (sync, active-high), bus (dmem_arbiter_if.slave).
module dmem_arbiter #(
    parameter int DEPTH   = 64,
    parameter int MEM_LAT = 2
) (
    input  logic           Clock,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAT_LD = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic          r_prio;
    logic          r_id;
    logic          r_wr;
    logic [CW-1:0] r_cnt;
    logic          r_gnt0, r_gnt1, r_done0, r_done1, r_err;
    logic [31:0]   r_rdata, r_maddr, r_mwdata;
    logic          r_mrd, r_mwr;

    logic          w_prio_n, w_id_n, w_wr_n;
    logic [CW-1:0] w_cnt_n;
    logic          w_gnt0_n, w_gnt1_n, w_done0_n, w_done1_n, w_err_n;
    logic [31:0]   w_rdata_n, w_maddr_n, w_mwdata_n;
    logic          w_mrd_n, w_mwr_n;

    logic          w_any, w_win, w_wr, w_legal;
    logic [31:0]   w_addr, w_wdata;

    // Single requester wins outright; on contention the pointer decides.
    assign w_any   = bus.Req0 | bus.Req1;
    assign w_win   = (bus.Req0 & bus.Req1) ? r_prio : bus.Req1;
    assign w_wr    = w_win ? bus.Wr1    : bus.Wr0;
    assign w_addr  = w_win ? bus.Addr1  : bus.Addr0;
    assign w_wdata = w_win ? bus.WData1 : bus.WData0;
    assign w_legal = (w_addr[1:0] == 2'b00) &&
                     (w_addr[31:2] < 30'(DEPTH));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_prio   <= 1'b0;
            r_id     <= 1'b0;
            r_wr     <= 1'b0;
            r_cnt    <= '0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_mrd    <= 1'b0;
            r_mwr    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_prio   <= w_prio_n;
            r_id     <= w_id_n;
            r_wr     <= w_wr_n;
            r_cnt    <= w_cnt_n;
            r_gnt0   <= w_gnt0_n;
            r_gnt1   <= w_gnt1_n;
            r_done0  <= w_done0_n;
            r_done1  <= w_done1_n;
            r_err    <= w_err_n;
            r_rdata  <= w_rdata_n;
            r_maddr  <= w_maddr_n;
            r_mwdata <= w_mwdata_n;
            r_mrd    <= w_mrd_n;
            r_mwr    <= w_mwr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any)
                    w_state_n = w_legal ? S_ACCESS : S_DONE;
            end
            S_ACCESS: begin
                if (r_cnt == '0)
                    w_state_n = S_DONE;
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        w_prio_n   = r_prio;
        w_id_n     = r_id;
        w_wr_n     = r_wr;
        w_cnt_n    = r_cnt;
        w_gnt0_n   = 1'b0;
        w_gnt1_n   = 1'b0;
        w_done0_n  = 1'b0;
        w_done1_n  = 1'b0;
        w_err_n    = r_err;
        w_rdata_n  = r_rdata;
        w_maddr_n  = r_maddr;
        w_mwdata_n = r_mwdata;
        w_mrd_n    = 1'b0;
        w_mwr_n    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_id_n   = w_win;
                    w_wr_n   = w_wr;
                    w_prio_n = ~w_win;
                    w_gnt0_n = ~w_win;
                    w_gnt1_n = w_win;
                    if (w_legal) begin
                        w_maddr_n  = w_addr;
                        w_mwdata_n = w_wdata;
                        w_mrd_n    = ~w_wr;
                        w_mwr_n    = w_wr;
                        w_cnt_n    = LAT_LD;
                    end else begin
                        // Rejected: complete immediately, memory untouched.
                        w_err_n   = 1'b1;
                        w_rdata_n = '0;
                        w_done0_n = ~w_win;
                        w_done1_n = w_win;
                    end
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_rdata_n = r_wr ? 32'h0 : bus.MemReadData;
                    w_err_n   = 1'b0;
                    w_done0_n = ~r_id;
                    w_done1_n = r_id;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                    w_mrd_n = r_mrd;
                    w_mwr_n = r_mwr;
                end
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
    end

    assign bus.Gnt0         = r_gnt0;
    assign bus.Gnt1         = r_gnt1;
    assign bus.Done0        = r_done0;
    assign bus.Done1        = r_done1;
    assign bus.Err          = r_err;
    assign bus.RData        = r_rdata;
    assign bus.MemAddress   = r_maddr;
    assign bus.MemWriteData = r_mwdata;
    assign bus.MemoryRead   = r_mrd;
    assign bus.MemoryWrite  = r_mwr;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// DataMemory (negedge write, combinational read).
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    int   both_cnt = 0;
    int   who;
    logic [31:0] mem [64];

    dmem_arbiter_if bus ();

    dmem_arbiter #(.DEPTH(64), .MEM_LAT(2)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.MemoryWrite)
            mem[bus.MemAddress[7:2]] <= bus.MemWriteData;

    assign bus.MemReadData = bus.MemoryRead ?
                             mem[bus.MemAddress[7:2]] : 32'h0;

    always @(posedge clk)
        if (bus.MemoryRead && bus.MemoryWrite)
            both_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int p, input logic v, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.Req0 = v; bus.Wr0 = wr; bus.Addr0 = a; bus.WData0 = d;
        end else begin
            bus.Req1 = v; bus.Wr1 = wr; bus.Addr1 = a; bus.WData1 = d;
        end
    endtask

    function automatic logic [1:0] gd(input int p);
        return (p == 0) ? {bus.Gnt0, bus.Done0} : {bus.Gnt1, bus.Done1};
    endfunction

    function automatic logic [1:0] stb();
        return {bus.MemoryRead, bus.MemoryWrite};
    endfunction

    task automatic access(input int p, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic bad, input logic [31:0] exp_rd,
                          input string tag);
        logic [1:0] s;
        s = wr ? 2'b01 : 2'b10;
        @(negedge clk);
        req(p, 1'b1, wr, a, d);
        @(negedge clk);
        req(p, 1'b0, 1'b0, 32'h0, 32'h0);
        if (bad) begin
            chk({tag, " gnt+done"}, 32'(gd(p)), 32'h3);
            chk({tag, " err"}, 32'(bus.Err), 32'h1);
            chk({tag, " rdata"}, bus.RData, 32'h0);
            chk({tag, " no strobe"}, 32'(stb()), 32'h0);
            chk({tag, " other"}, 32'(gd(1 - p)), 32'h0);
            @(negedge clk);
            chk({tag, " idle"}, 32'(gd(p)), 32'h0);
        end else begin
            chk({tag, " gnt"}, 32'(gd(p)), 32'h2);
            chk({tag, " strobe1"}, 32'(stb()), 32'(s));
            chk({tag, " maddr"}, bus.MemAddress, a);
            if (wr) chk({tag, " mwdata"}, bus.MemWriteData, d);
            chk({tag, " other"}, 32'(gd(1 - p)), 32'h0);
            @(negedge clk);
            chk({tag, " wait"}, 32'(gd(p)), 32'h0);
            chk({tag, " strobe2"}, 32'(stb()), 32'(s));
            @(negedge clk);
            chk({tag, " done"}, 32'(gd(p)), 32'h1);
            chk({tag, " err"}, 32'(bus.Err), 32'h0);
            chk({tag, " rdata"}, bus.RData, exp_rd);
            chk({tag, " strobe off"}, 32'(stb()), 32'h0);
            chk({tag, " other done"}, 32'(gd(1 - p)), 32'h0);
            @(negedge clk);
            chk({tag, " idle"}, 32'(gd(p)), 32'h0);
        end
    endtask

    task automatic wait_gnt(output int w);
        w = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.Gnt0 || bus.Gnt1) begin
                w = bus.Gnt1 ? 1 : 0;
                break;
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.Done0 || bus.Done1) begin
                seen = 1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("reset flags", {25'h0, bus.Gnt0, bus.Gnt1, bus.Done0,
            bus.Done1, bus.Err, bus.MemoryRead, bus.MemoryWrite}, 32'h0);
        chk("reset rdata", bus.RData, 32'h0);
        chk("reset maddr", bus.MemAddress, 32'h0);
        chk("reset mwdata", bus.MemWriteData, 32'h0);
        rst = 1'b0;

        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "p0 wr 10");
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "p0 rd 10");

        access(1, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, "p1 rd 102");

        access(0, 1'b1, 32'h100, 32'h55, 1'b1, 32'h0, "p0 wr 100");
        access(0, 1'b1, 32'hFC, 32'h1234, 1'b0, 32'h0, "p0 wr FC");
        access(0, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h1234, "p0 rd FC");

        access(1, 1'b1, 32'h20, 32'h5, 1'b0, 32'h0, "p1 wr 20");
        access(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h5, "p0 rd 20");
        @(negedge clk);
        req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        req(1, 1'b1, 1'b0, 32'h4, 32'h0);
        wait_gnt(who);
        chk("prio after p1,p0", 32'(who), 32'h1);
        req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_done("prio done");

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        req(1, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_gnt(who);
            chk($sformatf("rr grant %0d", k), 32'(who), 32'(k % 2));
        end
        req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_done("rr last done");
        chk("no dual strobe", 32'(both_cnt), 32'h0);

        @(negedge clk);
        req(0, 1'b1, 1'b1, 32'h30, 32'h77);
        @(negedge clk);
        req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort gnt", 32'(gd(0)), 32'h2);
        @(negedge clk);
        chk("abort wr held", 32'(stb()), 32'h1);
        rst = 1'b1;
        req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        req(1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        chk("abort strobes", 32'(stb()), 32'h0);
        chk("abort no gnt/done", {28'h0, gd(0), gd(1)}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset grant", {30'h0, bus.Gnt1, bus.Gnt0}, 32'h1);
        req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_done("post-reset done");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-port, 64-word DataMemory. It accepts word read/write requests from port 0 (CPU load/store) and port 1 (DMA/debug loader). It grants one request at a time round-robin and drives the memory's Address/WriteData/MemoryRead/MemoryWrite strobes for a fixed access window. It returns read data plus a one-cycle Done pulse to the granted requester, and rejects misaligned or out-of-range addresses without touching memory.

Parameters:
DEPTH, 64, memory depth in 32-bit words; legal byte addresses are 0..4*DEPTH-4.
MEM_LAT, 2, cycles the strobes are held per access; covers negedge write and posedge read with delay.

Ports:
Clock  input  1  system clock, all state on posedge
Reset  input  1  synchronous, active-high reset
Req0  input  1  port 0 request; hold until Gnt0
Wr0  input  1  port 0 op: 1=write, 0=read
Addr0  input  32  port 0 byte address
WData0  input  32  port 0 write data
Gnt0  output  1  one-cycle pulse: port 0 request accepted and fields captured
Done0  output  1  one-cycle pulse: port 0 access complete
Req1, Wr1, Addr1, WData1, Gnt1, Done1  same as port 0, for port 1
RData  output  32  read data, valid while Done0/Done1 is high
Err  output  1  valid with Done; 1 = rejected address
MemAddress  output  32  to DataMemory Address
MemWriteData  output  32  to DataMemory WriteData
MemoryRead  output  1  to DataMemory MemoryRead
MemoryWrite  output  1  to DataMemory MemoryWrite
MemReadData  input  32  from DataMemory ReadData

Behaviour:
- All outputs are registered. On Reset: state IDLE; Gnt*, Done*, Err, MemoryRead, MemoryWrite = 0; RData, MemAddress, MemWriteData = 0; priority pointer = port 0; latency counter = 0.
- States: IDLE, ACCESS, DONE.
- IDLE with no Req: remain in IDLE.
- IDLE with a Req: choose the winner. If only one port requests, it wins. If both request, the port named by the priority pointer wins.
- On that same edge: latch the winner's Wr/Addr/WData and winner id, pulse the winner's Gnt for the next cycle, and point the priority pointer at the other port.
- Legality check on the latched Addr: Addr[1:0]==0 and Addr[31:2] < DEPTH.
- Legal: go to ACCESS. MemAddress = Addr. MemWriteData = WData. Exactly one of MemoryWrite (Wr=1) or MemoryRead (Wr=0) goes high. Counter loads MEM_LAT-1.
- Illegal: go to DONE with Err=1 and RData=0. No strobe is raised.
- ACCESS: strobes and MemAddress/MemWriteData are held stable; the counter decrements each cycle.
- When the counter reaches 0: drop both strobes; for a read, capture MemReadData into RData (for a write, RData=0); Err=0; go to DONE.
- DONE: the winner's Done is high for exactly this one cycle, then return to IDLE. Re-arbitration is not possible in the DONE cycle.
- Latency for a legal access: Gnt is high in cycle T+1 after the arbitration edge T, and Done is high in cycle T+1+MEM_LAT. Illegal access: Done is high in cycle T+1, concurrent with Gnt.
- MemoryRead and MemoryWrite are never both high. Strobes are low in IDLE and DONE.
- Req is sampled only in IDLE. A Req held high after Done is treated as a new request. Requester inputs may change freely after Gnt.
- Address is passed through unshifted; DataMemory performs the >>2.
- Reset mid-ACCESS: strobes drop at that edge and state goes to IDLE. No Done is issued, and the aborted request is not retried.
- Reset in the same cycle as Req: reset wins and no Gnt is issued.
- Only Done can be observed for the granted port; the other port's Gnt/Done stay 0.

Test Plan:
- Port 0 write Addr0=0x10, WData0=0xDEADBEEF, then read 0x10 (MEM_LAT=2) -> write: Gnt0 at T+1, MemoryWrite high 2 cycles, Done0 at T+3 with Err=0; read: RData=0xDEADBEEF with Done0, MemoryRead high 2 cycles, Done0 at T+3.
- Req0 and Req1 both held continuously, reads of 0x0 and 0x4 -> grants alternate 0,1,0,1 after reset; no cycle has both strobes high.
- Port 1 read Addr1=0x102 (misaligned) -> Gnt1 and Done1 in the same cycle, Err=1, RData=0, MemoryRead never asserted.
- Port 0 write Addr0=0x100 (word 64, DEPTH=64) -> Err=1, no MemoryWrite. Then Addr0=0xFC -> Err=0 and a normal access.
- Assert Reset on the second ACCESS cycle of a port 0 write -> strobes low next cycle, Done0 never pulses, next grant after reset goes to port 0 when both request.
- Req1 alone write 0x20=5, then Req0 alone read 0x20 -> RData=5; priority pointer after the two grants points at port 1.
